// File: rtl/uart_pkt_tx.sv
// rtl/uart_pkt_tx.sv - word FIFO feeding a byte-ordered UART serialiser (8 data, opt. even parity, 1 stop)
module uart_pkt_tx #(
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 868,
    parameter int MSB_FIRST    = 1,
    parameter int PARITY_EN    = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             data,
    input  logic                          valid,
    output logic                          ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BYTES  = DATA_W / 8;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ready_q, ready_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d, byte_sel;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [7:0]          byte_q, byte_d;
    logic                tx_q, tx_d;
    logic                push, pop, bit_end, last_byte, fifo_nempty;

    assign push        = valid && ready_q;
    assign bit_end     = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign last_byte   = (byte_idx_q == BIDX_W'(BYTES - 1));
    assign fifo_nempty = (count_q != '0);

    assign ready      = ready_q;
    assign uart_tx    = tx_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != S_IDLE) || fifo_nempty;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (fifo_nempty) state_d = S_LOAD;
            S_LOAD:   state_d = S_START;
            S_START:  if (bit_end) state_d = S_DATA;
            S_DATA:   if (bit_end && bit_idx_q == 3'd7)
                          state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP:   if (bit_end)
                          state_d = (!last_byte || fifo_nempty) ? S_LOAD : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // tx_d is registered, so the line lags the state by one cycle uniformly
    always_comb begin
        pop  = 1'b0;
        tx_d = 1'b1;
        case (state_q)
            S_IDLE:   pop  = fifo_nempty;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = byte_q[bit_idx_q];
            S_PARITY: tx_d = ^byte_q;
            S_STOP:   pop  = bit_end && last_byte && fifo_nempty;
            default:  ;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data;
    end

    always_comb begin
        cnt_d = (bit_end || state_q == S_IDLE || state_q == S_LOAD) ? '0 : cnt_q + 1'b1;

        bit_idx_d = bit_idx_q;
        if (state_q == S_LOAD)
            bit_idx_d = '0;
        else if (state_q == S_DATA && bit_end)
            bit_idx_d = bit_idx_q + 1'b1;

        byte_idx_d = byte_idx_q;
        if (pop)
            byte_idx_d = '0;
        else if (state_q == S_STOP && bit_end && !last_byte)
            byte_idx_d = byte_idx_q + 1'b1;

        word_d = pop ? mem_q[rd_ptr_q] : word_q;

        byte_sel = (MSB_FIRST != 0) ? BIDX_W'(BYTES - 1) - byte_idx_q : byte_idx_q;
        byte_d   = byte_q;
        if (state_q == S_LOAD) begin
            for (int i = 0; i < BYTES; i++) begin
                if (byte_sel == BIDX_W'(i)) byte_d = word_q[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            byte_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            byte_q     <= byte_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_pkt_tx.sv
// tb/tb_uart_pkt_tx.sv - directed self-checking bench for uart_pkt_tx
module tb_uart_pkt_tx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        valid0, valid1, valid2;
    logic [15:0] data0, data1;
    logic [31:0] data2;
    logic        ready0, ready1, ready2;
    logic        tx0, tx1, tx2;
    logic        busy0, busy1, busy2;
    logic [2:0]  cnt0, cnt1, cnt2;

    int          dsel;
    logic        line, busy_m;
    assign line   = (dsel == 0) ? tx0   : (dsel == 1) ? tx1   : tx2;
    assign busy_m = (dsel == 0) ? busy0 : (dsel == 1) ? busy1 : busy2;

    int          evals = 0;
    int          fails = 0;
    logic [7:0]  eb [0:15];
    logic [15:0] w3 [0:5];
    bit          r, saw_full, hi;
    int          n;

    uart_pkt_tx #(.DATA_W(16), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .MSB_FIRST(1), .PARITY_EN(0)) u0 (
        .clk(clk), .rst_n(rst_n), .data(data0), .valid(valid0), .ready(ready0),
        .uart_tx(tx0), .busy(busy0), .fifo_count(cnt0));

    uart_pkt_tx #(.DATA_W(16), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .MSB_FIRST(0), .PARITY_EN(1)) u1 (
        .clk(clk), .rst_n(rst_n), .data(data1), .valid(valid1), .ready(ready1),
        .uart_tx(tx1), .busy(busy1), .fifo_count(cnt1));

    uart_pkt_tx #(.DATA_W(32), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .MSB_FIRST(1), .PARITY_EN(0)) u2 (
        .clk(clk), .rst_n(rst_n), .data(data2), .valid(valid2), .ready(ready2),
        .uart_tx(tx2), .busy(busy2), .fifo_count(cnt2));

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        evals++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input int d, input logic [31:0] w);
        @(posedge clk); #1;
        case (d)
            0:       begin valid0 = 1'b1; data0 = w[15:0]; end
            1:       begin valid1 = 1'b1; data1 = w[15:0]; end
            default: begin valid2 = 1'b1; data2 = w;       end
        endcase
        @(posedge clk); #1;
        valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
    endtask

    task automatic wait_start(output int cycles);
        cycles = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            cycles++;
            if (line === 1'b0) return;
        end
        chk(32'(line), 32'd0, "start_timeout");
    endtask

    // Checks every cycle of each frame plus the single high cycle between frames
    task automatic check_stream(input int nb, input bit par, input bit do_wait);
        int   nbits, w;
        logic e;
        if (do_wait) begin
            wait_start(w);
            if (line !== 1'b0) return;
        end
        nbits = par ? 11 : 10;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < nbits; k++) begin
                if (k == 0)             e = 1'b0;
                else if (k <= 8)        e = eb[b][k-1];
                else if (par && k == 9) e = ^eb[b];
                else                    e = 1'b1;
                for (int c = 0; c < 4; c++) begin
                    chk(32'(line), 32'(e), $sformatf("frame_b%0d_bit%0d_cyc%0d", b, k, c));
                    if (!(b == nb - 1 && k == nbits - 1 && c == 3)) @(negedge clk);
                end
            end
            if (b < nb - 1) begin
                chk(32'(line), 32'd1, $sformatf("gap_after_b%0d", b));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
        data0 = '0; data1 = '0; data2 = '0;
        dsel = 0;
        w3[0] = 16'h1234; w3[1] = 16'hA55A; w3[2] = 16'h00FF;
        w3[3] = 16'h8001; w3[4] = 16'hC3E7; w3[5] = 16'h7E81;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(32'(tx0), 32'd1, "rst_tx");
        chk(32'(ready0), 32'd0, "rst_ready");
        chk(32'(busy0), 32'd0, "rst_busy");
        chk(32'(cnt0), 32'd0, "rst_count");
        chk(32'(tx2), 32'd1, "rst_tx_u2");
        rst_n = 1'b1;
        @(negedge clk);
        chk(32'(ready0), 32'd1, "ready_after_release");
        chk(32'(ready1), 32'd1, "ready_after_release_u1");

        // MSB first, no parity
        dsel = 0;
        eb[0] = 8'h4F; eb[1] = 8'h3E;
        push_word(0, 32'h4F3E);
        wait_start(n);
        chk(32'(n), 32'd4, "start_latency");
        chk(32'(busy0), 32'd1, "busy_in_frame");
        check_stream(2, 1'b0, 1'b0);
        chk(32'(busy0), 32'd0, "busy_drop_t1");
        chk(32'(cnt0), 32'd0, "count_t1");

        // LSB first with even parity
        dsel = 1;
        eb[0] = 8'h3E; eb[1] = 8'h4F;
        push_word(1, 32'h4F3E);
        check_stream(2, 1'b1, 1'b1);
        chk(32'(busy_m), 32'd0, "busy_drop_t2");

        // Back-pressure: six words with valid held, junk offered while full
        dsel = 0;
        for (int i = 0; i < 6; i++) begin
            eb[2*i]   = w3[i][15:8];
            eb[2*i+1] = w3[i][7:0];
        end
        saw_full = 1'b0;
        fork
            begin
                @(posedge clk); #1;
                for (int i = 0; i < 6; i++) begin
                    data0  = w3[i];
                    valid0 = 1'b1;
                    for (int t = 0; t < 400; t++) begin
                        @(negedge clk);
                        r = ready0;
                        if (!r) begin
                            saw_full = 1'b1;
                            chk(32'(cnt0), 32'd4, "full_count_hold");
                            data0 = 16'hDEAD ^ 16'(t);
                        end
                        @(posedge clk); #1;
                        if (r) break;
                        data0 = w3[i];
                    end
                end
                valid0 = 1'b0;
            end
            begin
                check_stream(12, 1'b0, 1'b1);
            end
        join
        chk(32'(saw_full), 32'd1, "ready_deasserted");
        chk(32'(busy0), 32'd0, "busy_drop_t3");
        chk(32'(cnt0), 32'd0, "count_t3");

        // 32-bit word, MSB first
        dsel = 2;
        eb[0] = 8'hDE; eb[1] = 8'hAD; eb[2] = 8'hBE; eb[3] = 8'hEF;
        push_word(2, 32'hDEADBEEF);
        check_stream(4, 1'b0, 1'b1);
        chk(32'(busy_m), 32'd0, "busy_drop_t4");

        // Reset in the middle of the data bits of the first byte
        dsel = 0;
        push_word(0, 32'h4F3E);
        push_word(0, 32'h1111);
        wait_start(n);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk(32'(line), 32'd1, "abort_tx_high");
        chk(32'(cnt0), 32'd0, "abort_count");
        chk(32'(busy0), 32'd0, "abort_busy");
        rst_n = 1'b1;
        hi = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (line !== 1'b1 || busy0 !== 1'b0) hi = 1'b0;
        end
        chk(32'(hi), 32'd1, "no_resume_after_reset");
        eb[0] = 8'h5A; eb[1] = 8'hA5;
        push_word(0, 32'h5AA5);
        check_stream(2, 1'b0, 1'b1);
        chk(32'(busy0), 32'd0, "busy_drop_t5");

        $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
        $finish;
    end

endmodule
